// File: rtl/rv_dm_wb_bridge.sv
// rv_dm_wb_bridge: runs each core load/store as one Wishbone classic cycle, with a bus timeout.
module rv_dm_wb_bridge #(
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hFFFF_FFFF
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_data_s_i,
    input  logic [3:0]  dm_data_select_i,
    input  logic        dm_load_i,
    input  logic        dm_store_i,
    output logic        dm_ready_o,
    output logic [31:0] dm_data_l_o,
    output logic        dm_load_done_o,
    output logic        dm_store_done_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [3:0]  wb_sel_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    output logic        bus_err_o,
    input  logic        bus_err_clr_i
);
    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'((TIMEOUT < 1) ? 0 : TIMEOUT - 1);
    typedef enum logic {IDLE, BUS} state_t;
    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic          accept, timeout, term, fail;
    assign dm_ready_o = state == IDLE;
    assign wb_cyc_o   = state == BUS;
    assign wb_stb_o   = state == BUS;
    always_comb begin
        accept    = (dm_load_i | dm_store_i) & (state == IDLE);
        timeout   = (TIMEOUT != 0) && (cnt == LAST);
        term      = (state == BUS) & (wb_ack_i | wb_err_i | timeout);
        fail      = wb_err_i | (~wb_ack_i & timeout);
        state_nxt = accept ? BUS : term ? IDLE : state;
    end
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state <= IDLE;
        else          state <= state_nxt;
    end
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt             <= '0;
            wb_adr_o        <= '0;
            wb_sel_o        <= '0;
            wb_dat_o        <= '0;
            wb_we_o         <= 1'b0;
            dm_data_l_o     <= '0;
            dm_load_done_o  <= 1'b0;
            dm_store_done_o <= 1'b0;
            bus_err_o       <= 1'b0;
        end else begin
            cnt             <= accept ? '0 : (state == BUS) ? cnt + 1'b1 : cnt;
            dm_load_done_o  <= term & ~wb_we_o;
            dm_store_done_o <= term & wb_we_o;
            bus_err_o       <= (term & fail) | (bus_err_o & ~bus_err_clr_i);
            if (accept) begin
                wb_adr_o <= dm_addr_i & 32'hFFFF_FFFC;
                wb_sel_o <= dm_data_select_i;
                wb_dat_o <= dm_data_s_i;
                wb_we_o  <= dm_store_i;
            end
            if (term & ~wb_we_o) dm_data_l_o <= fail ? ERR_DATA : wb_dat_i;
        end
    end
endmodule

// File: tb/tb_rv_dm_wb_bridge.sv
// tb_rv_dm_wb_bridge: vector table, hand sequences and random transfers against a transaction-level model.
module tb_rv_dm_wb_bridge;
    localparam int          T  = 8;
    localparam logic [31:0] ED = 32'hFFFF_FFFF;
    logic        clk = 0, rst_n = 0;
    logic [31:0] dm_addr = 0, dm_data_s = 0, wb_dat_i = 0;
    logic [3:0]  dm_sel = 0;
    logic        dm_load = 0, dm_store = 0, wb_ack = 0, wb_err = 0, clr = 0;
    logic        dm_ready_o, dm_load_done_o, dm_store_done_o, wb_cyc_o, wb_stb_o, wb_we_o, bus_err_o;
    logic [31:0] dm_data_l_o, wb_adr_o, wb_dat_o;
    logic [3:0]  wb_sel_o;
    always #5 clk = ~clk;
    rv_dm_wb_bridge #(.TIMEOUT(T), .ERR_DATA(ED)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .dm_addr_i(dm_addr), .dm_data_s_i(dm_data_s),
        .dm_data_select_i(dm_sel), .dm_load_i(dm_load), .dm_store_i(dm_store),
        .dm_ready_o(dm_ready_o), .dm_data_l_o(dm_data_l_o), .dm_load_done_o(dm_load_done_o),
        .dm_store_done_o(dm_store_done_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
        .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack), .wb_err_i(wb_err), .bus_err_o(bus_err_o),
        .bus_err_clr_i(clr)
    );
    int n_cmp = 0, n_err = 0;
    logic [31:0] data_exp = 0;
    logic        err_exp = 0;
    typedef struct {
        logic        ld, st;
        logic [31:0] a, d;
        logic [3:0]  s;
        int          wt, mode;
        logic [31:0] rd;
        logic        clr;
    } vec_t;
    vec_t tbl[8];
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask
    // mode: 0 ack, 1 err, 2 silent slave, 3 ack+err together; wt = stb cycles before the response
    task automatic run(input vec_t v, input string nm);
        int   ncyc, term, strobes;
        logic we_e, fail, moved;
        we_e  = v.st;
        term  = (v.mode != 2 && v.wt < T) ? v.wt : T - 1;
        fail  = (v.mode != 0) || (v.wt >= T);
        moved = 0;
        strobes = 0;
        chk({nm, " ready"}, dm_ready_o, 1);
        dm_load = v.ld; dm_store = v.st; dm_addr = v.a; dm_data_s = v.d; dm_sel = v.s; clr = v.clr;
        @(negedge clk);
        dm_load = 0; dm_store = 0; dm_addr = $urandom; dm_data_s = $urandom; dm_sel = 4'($urandom);
        chk({nm, " adr"}, wb_adr_o, {v.a[31:2], 2'b00});
        chk({nm, " we"}, wb_we_o, we_e);
        chk({nm, " sel"}, wb_sel_o, v.s);
        chk({nm, " dat_o"}, wb_dat_o, v.d);
        ncyc = 0;
        while (wb_cyc_o === 1 && ncyc < 40) begin
            if (wb_adr_o !== {v.a[31:2], 2'b00} || wb_we_o !== we_e || wb_sel_o !== v.s ||
                wb_dat_o !== v.d || wb_stb_o !== 1 || dm_ready_o !== 0) moved = 1;
            strobes += int'(dm_load_done_o) + int'(dm_store_done_o);
            wb_ack   = (v.mode == 0 || v.mode == 3) && ncyc == v.wt;
            wb_err   = (v.mode == 1 || v.mode == 3) && ncyc == v.wt;
            wb_dat_i = v.rd;
            ncyc++;
            @(negedge clk);
            wb_ack = 0; wb_err = 0; wb_dat_i = $urandom;
        end
        if (!we_e) data_exp = fail ? ED : v.rd;
        err_exp = fail ? 1'b1 : (v.clr ? 1'b0 : err_exp);
        chk({nm, " held during bus"}, moved, 0);
        chk({nm, " no early done"}, strobes, 0);
        chk({nm, " cyc cycles"}, ncyc, term + 1);
        chk({nm, " stb low"}, wb_stb_o, 0);
        chk({nm, " ready after"}, dm_ready_o, 1);
        chk({nm, " load_done"}, dm_load_done_o, !we_e);
        chk({nm, " store_done"}, dm_store_done_o, we_e);
        chk({nm, " data_l"}, dm_data_l_o, data_exp);
        chk({nm, " bus_err"}, bus_err_o, err_exp);
        clr = 0;
        @(negedge clk);
        chk({nm, " load_done pulse"}, dm_load_done_o, 0);
        chk({nm, " store_done pulse"}, dm_store_done_o, 0);
        chk({nm, " data_l held"}, dm_data_l_o, data_exp);
    endtask
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        tbl[0] = '{1, 0, 32'h0000_1004, 32'h0, 4'hF, 3, 0, 32'hDEAD_BEEF, 0};
        tbl[1] = '{0, 1, 32'h0000_2003, 32'h0000_00AB, 4'b1000, 0, 0, 32'h0, 0};
        tbl[2] = '{0, 1, 32'h0000_3000, 32'h1111_2222, 4'h3, 1, 1, 32'h0, 0};
        tbl[3] = '{1, 1, 32'h0000_4008, 32'h0000_0055, 4'hF, 0, 0, 32'h7777_7777, 0};
        tbl[4] = '{1, 0, 32'h0000_5000, 32'h0, 4'hF, 0, 2, 32'h1357_9BDF, 0};
        tbl[5] = '{1, 0, 32'h0000_5004, 32'h0, 4'hF, 7, 0, 32'h1234_5678, 1};
        tbl[6] = '{1, 0, 32'h0000_5008, 32'h0, 4'hF, 2, 3, 32'h0000_A5A5, 0};
        tbl[7] = '{1, 0, 32'h0000_500C, 32'h0, 4'hF, 8, 0, 32'h2468_ACE0, 0};
        #3;
        chk("rst ready", dm_ready_o, 1);
        chk("rst cyc/stb/we", {wb_cyc_o, wb_stb_o, wb_we_o}, 0);
        chk("rst adr", wb_adr_o, 0);
        chk("rst sel", wb_sel_o, 0);
        chk("rst dat_o", wb_dat_o, 0);
        chk("rst data_l", dm_data_l_o, 0);
        chk("rst done/err", {dm_load_done_o, dm_store_done_o, bus_err_o}, 0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) run(tbl[i], $sformatf("vec%0d", i));
        chk("err before clr", bus_err_o, 1);
        clr = 1;
        @(negedge clk);
        clr = 0;
        err_exp = 0;
        chk("err after clr", bus_err_o, 0);
        begin
            int issued = 0, dn = 0, cy = 0;
            for (int c = 0; c < 12; c++) begin
                if (dm_load_done_o) begin
                    chk($sformatf("b2b data%0d", dn), dm_data_l_o, (32'h100 + 32'(4 * dn)) ^ 32'hB000_0000);
                    dn++;
                end
                cy += int'(wb_cyc_o);
                wb_ack   = wb_cyc_o;
                wb_dat_i = wb_adr_o ^ 32'hB000_0000;
                dm_load  = dm_ready_o && issued < 4;
                dm_addr  = 32'h100 + 32'(4 * issued);
                dm_sel   = 4'hF;
                if (dm_load) issued++;
                @(negedge clk);
            end
            dm_load = 0; wb_ack = 0;
            chk("b2b load_done count", dn, 4);
            chk("b2b cyc cycles", cy, 4);
            data_exp = 32'h10C ^ 32'hB000_0000;
        end
        wb_ack = 1; wb_err = 1;
        @(negedge clk);
        wb_ack = 0; wb_err = 0;
        chk("idle ack ignored", {dm_ready_o, wb_cyc_o, dm_load_done_o, dm_store_done_o, bus_err_o}, 5'b10000);
        for (int i = 0; i < 30; i++) begin
            vec_t v;
            v.ld   = 1'($urandom_range(0, 1));
            v.st   = v.ld ? 1'($urandom_range(0, 1)) : 1'b1;
            v.a    = $urandom;
            v.d    = $urandom;
            v.s    = 4'($urandom);
            v.wt   = $urandom_range(0, 9);
            v.mode = $urandom_range(0, 3);
            v.rd   = $urandom;
            v.clr  = $urandom_range(0, 3) == 0;
            run(v, $sformatf("rnd%0d", i));
        end
        dm_load = 1; dm_addr = 32'h6000; dm_sel = 4'hF;
        @(negedge clk);
        dm_load = 0;
        chk("pre-reset cyc", wb_cyc_o, 1);
        #2 rst_n = 0;
        #1;
        chk("async drop cyc/stb", {wb_cyc_o, wb_stb_o}, 0);
        chk("async ready", dm_ready_o, 1);
        @(negedge clk);
        rst_n = 1;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("post-reset done%0d", c), {dm_load_done_o, dm_store_done_o}, 0);
            chk($sformatf("post-reset ready%0d", c), dm_ready_o, 1);
            @(negedge clk);
        end
        chk("post-reset data_l", dm_data_l_o, 0);
        chk("post-reset bus_err", bus_err_o, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/rv_dm_wb_bridge.md
# rv_dm_wb_bridge

Data-memory bus bridge sitting directly downstream of the CPU core's data-memory port. It accepts single load/store requests from the core's execute/writeback stages and runs each as one Wishbone classic cycle. It returns load data and completion strobes to the core. A bus timeout is included so that a dead slave cannot hang the pipeline.

## Interface
Parameters:
- `TIMEOUT`, default 255: maximum bus cycles a transfer may wait for ack/err; 0 disables the timeout.
- `ERR_DATA`, default 32'hFFFF_FFFF: load data returned on an error or timeout.

Ports:
- `clk_i` in 1: single clock. All logic is on the rising edge.
- `rst_n_i` in 1: reset, asynchronous and active-low.
- `dm_addr_i` in 32: byte address from the core.
- `dm_data_s_i` in 32: store data.
- `dm_data_select_i` in 4: byte lane enables.
- `dm_load_i` in 1: load request.
- `dm_store_i` in 1: store request.
- `dm_ready_o` out 1: bridge can accept a request this cycle.
- `dm_data_l_o` out 32: load data.
- `dm_load_done_o` out 1: load complete strobe.
- `dm_store_done_o` out 1: store complete strobe.
- `wb_cyc_o` out 1, `wb_stb_o` out 1, `wb_we_o` out 1: Wishbone cycle controls.
- `wb_adr_o` out 32, `wb_sel_o` out 4, `wb_dat_o` out 32: Wishbone address, byte select, write data.
- `wb_dat_i` in 32, `wb_ack_i` in 1, `wb_err_i` in 1: Wishbone read data and termination.
- `bus_err_o` out 1: sticky error flag.
- `bus_err_clr_i` in 1: clears `bus_err_o`.

## Operation
- FSM has two states, IDLE and BUS.
- **Acceptance:** a request is accepted when (`dm_load_i` | `dm_store_i`) & `dm_ready_o`. `dm_ready_o` = (state==IDLE).
  - Requests presented while `dm_ready_o`=0 are ignored, not queued.
- **Simultaneous load and store:** this is a protocol violation. The store is taken and the load is dropped.
- **On accept:** the bridge registers the following and moves to BUS:
  - `wb_adr_o` = {`dm_addr_i`[31:2], 2'b00}
  - `wb_sel_o` = `dm_data_select_i`
  - `wb_dat_o` = `dm_data_s_i`
  - `wb_we_o` = store
- **In BUS:** `wb_cyc_o`=`wb_stb_o`=1. Address, select, data and we are held stable. A timeout counter increments each BUS cycle.
- **Termination:** occurs on whichever comes first: `wb_ack_i`, `wb_err_i`, or counter==`TIMEOUT`-1 with no ack/err (only when `TIMEOUT`≠0).
  - ack and err asserted in the same cycle: treated as err.
  - On termination the FSM returns to IDLE. cyc/stb deassert on the next edge.
- **Load completion:**
  - `dm_data_l_o` is registered at termination: `wb_dat_i` on ack, `ERR_DATA` on err or timeout.
  - It holds that value until the next load completes.
- **Completion strobe:** `dm_load_done_o` or `dm_store_done_o` (matching `wb_we_o`) is a one-cycle pulse in the first IDLE cycle after termination.
- **Error flag:** `bus_err_o` sets on err or timeout.
  - `bus_err_clr_i` clears it; if set and clear occur in the same cycle, set wins.
- **Counter width:** `$clog2(TIMEOUT+1)`, minimum 1. The counter resets to 0 on every accept.

## Timing
- **Reset values (async, `rst_n_i`=0):**
  - State IDLE, so `dm_ready_o`=1.
  - cyc/stb/we = 0; adr/sel/dat_o = 0.
  - `dm_data_l_o`=0; done strobes 0; `bus_err_o`=0; counter 0.
- **Reset mid-transfer:** cyc/stb drop immediately (asynchronously) and no done strobe is issued.
- **Request timeline:** request accepted at edge N → cyc/stb high from cycle N+1.
- **Termination timeline:** ack sampled at edge M → cyc/stb low, done pulse and `dm_ready_o`=1 all in cycle M+1.
- **Back-to-back:** a new request can be accepted in cycle M+1, giving cyc high again at M+2. The minimum gap of one idle bus cycle between transfers is by design.
- **Minimum latency:** ack in the first stb cycle gives accept → done = 2 cycles.
- **Timeout:** with `TIMEOUT`=T, cyc stays high for exactly T cycles, then the done pulse follows.
- **Single-cycle ack only:** ack/err sampled while in IDLE are ignored.

## Test plan
- **Aligned load:** load addr 0x0000_1004, sel 4'hF; slave acks 3 cycles after stb with 0xDEAD_BEEF → `wb_adr_o`=0x1004 and `wb_we_o`=0 throughout; `dm_load_done_o` is a 1-cycle pulse; `dm_data_l_o`=0xDEAD_BEEF and held afterwards.
- **Byte store:** store addr 0x0000_2003, data 0x0000_00AB, sel 4'b1000; immediate ack → `wb_adr_o`=0x2000, `wb_sel_o`=4'b1000, `wb_we_o`=1; `dm_store_done_o` pulses 2 cycles after accept; `dm_load_done_o` stays 0.
- **Back-to-back:** 4 loads issued whenever `dm_ready_o`=1, zero-wait slave → exactly 4 load_done pulses, cyc high 1 of every 2 cycles, data returned in order.
- **Timeout:** `TIMEOUT`=8, slave never acks → cyc high for exactly 8 cycles; `dm_data_l_o`=0xFFFF_FFFF; `bus_err_o`=1 until `bus_err_clr_i` is pulsed, after which it reads 0.
- **Error and collision:** `wb_err_i` on a store → `dm_store_done_o` pulses and `bus_err_o`=1; load and store asserted together → a single write cycle and a single store_done.
- **Reset mid-cycle:** `rst_n_i` asserted while cyc=1 → cyc/stb drop without waiting for a clock edge; after release, `dm_ready_o`=1 and no done pulse is seen.
